// File: rtl/swc_4to1.sv
// swc_4to1: wide-to-narrow sample-width converter.
// Accepts one 4*DW-bit word per handshake and emits it as four DW-bit words,
// lane 0 (least significant) first. Both sides use valid/ready flow control.
module swc_4to1 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4*DW-1:0] data_in,
    input  logic            valid_in,
    output logic            ready_in,
    output logic [DW-1:0]   data_out,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [1:0]      lane_out,
    output logic            last_out
);

    // Selects one narrow lane out of a wide word.
    function automatic logic [DW-1:0] lane_sel(input logic [4*DW-1:0] w,
                                               input logic [1:0]      l);
        logic [DW-1:0] r;
        case (l)
            2'd0:    r = w[DW-1:0];
            2'd1:    r = w[2*DW-1:DW];
            2'd2:    r = w[3*DW-1:2*DW];
            2'd3:    r = w[4*DW-1:3*DW];
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [4*DW-1:0] buf_q, buf_d;
    logic [1:0]      lane_q, lane_d;
    logic            full_q, full_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            last_q, last_d;
    logic            in_xfer_s;
    logic            out_xfer_s;
    logic            lane_is_last_s;

    assign lane_is_last_s = (lane_q == 2'd3);

    // ready_in looks through to ready_out so the next word loads on the
    // same edge that retires the final lane, giving bubble-free streaming.
    assign ready_in   = !reset & (!full_q | (lane_is_last_s & ready_out));
    assign in_xfer_s  = valid_in & ready_in;
    assign out_xfer_s = full_q & ready_out;

    assign valid_out = full_q;
    assign lane_out  = lane_q;
    assign data_out  = dout_q;
    assign last_out  = last_q;

    // Next-state: a load always wins; otherwise an out-transfer advances
    // the lane or, on the last lane, empties the buffer.
    always_comb begin
        buf_d  = buf_q;
        lane_d = lane_q;
        full_d = full_q;
        if (in_xfer_s) begin
            buf_d  = data_in;
            lane_d = 2'd0;
            full_d = 1'b1;
        end else if (out_xfer_s) begin
            if (lane_is_last_s) begin
                lane_d = 2'd0;
                full_d = 1'b0;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end else begin
            lane_d = lane_q;
        end
        // Output registers are preloaded with the lane that will be shown
        // after this edge, keeping data_out/last_out glitch-free.
        dout_d = lane_sel(buf_d, lane_d);
        last_d = full_d & (lane_d == 2'd3);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            lane_q <= 2'd0;
            full_q <= 1'b0;
            dout_q <= '0;
            last_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            lane_q <= lane_d;
            full_q <= full_d;
            dout_q <= dout_d;
            last_q <= last_d;
        end
    end

endmodule

// File: doc/swc_4to1.md
# swc_4to1

Wide-to-narrow sample-width converter: accepts one 4*DW-bit word per handshake and emits it as four consecutive DW-bit words, lane 0 (bits DW-1:0) first. It is the unpacking counterpart of the 1-to-4 packer. It sits on the transmit side, between wide buffering (FIFO/DMA) and narrow per-sample datapaths. Both sides use valid/ready flow control, so no data is ever dropped.

## Interface
- DW, default 8: narrow word width in bits. Set in the parent module; must be ≥1.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  4*DW  wide word; lane k = data_in[(k+1)*DW-1 : k*DW].
- valid_in  input  1  data_in is valid.
- ready_in  output  1  converter can accept data_in this cycle.
- data_out  output  DW  current narrow word.
- valid_out  output  1  data_out is valid.
- ready_out  input  1  downstream accepts data_out this cycle.
- lane_out  output  2  index (0..3) of the lane currently on data_out.
- last_out  output  1  high when lane_out==3 (final lane of a wide word).

## Operation
- State: word_buf[4*DW], lane[1:0], full (1 = word_buf holds lanes not yet transferred).
- In-transfer: valid_in & ready_in at a clock edge. Out-transfer: valid_out & ready_out at a clock edge.
- ready_in = !reset & (!full | (lane==3 & ready_out)). This is combinational from ready_out, so a new word loads on the same edge as the final lane's out-transfer.
- valid_out = full.
- data_out = word_buf lane selected by lane.
- lane_out = lane.
- last_out = full & (lane==3).
- Outputs derive only from registers, except ready_in.
- On in-transfer: word_buf <= data_in, lane <= 0, full <= 1.
- On out-transfer with lane<3: lane <= lane+1, full stays 1.
- On out-transfer with lane==3 and no simultaneous in-transfer: full <= 0, lane <= 0.
- Simultaneous lane-3 out-transfer and in-transfer: the load wins, so full stays 1 and lane <= 0.
- While ready_out=0: data_out, lane_out, last_out and valid_out hold stable. Once valid_out is asserted it does not deassert before its out-transfer.
- valid_in with ready_in=0: no state change. Upstream holds the word.
- Lane counter never wraps without an out-transfer. Lane 3 never advances to 0 except via the rules above.

## Timing
- Reset (async assert, sync release at the clk edge): word_buf=0, lane=0, full=0. Outputs: valid_out=0, data_out=0, lane_out=0, last_out=0, ready_in=0 while reset is high and 1 after release.
- Latency: a word accepted at edge N shows lane 0 on data_out in cycle N+1, i.e. after that edge.
- With ready_out held high, lanes 0..3 appear in cycles N+1..N+4.
- Throughput: sustained 1 narrow word/cycle. Back-to-back wide words every 4 cycles with no bubble when valid_in is high at each lane-3 edge.
- Empty with valid_in high: accept on the next edge. There is no bypass, so the minimum latency is 1 cycle.
- Reset mid-word: the partially sent word is discarded and valid_out drops immediately (asynchronously).

## Test plan
- Reset: assert reset mid-stream with lane=2 → valid_out=0, lane_out=0, data_out=0, ready_in=0 immediately. After release, ready_in=1.
- Single word, DW=8: data_in=0xDDCCBBAA, ready_out=1 → data_out=AA,BB,CC,DD in cycles N+1..N+4. last_out=1 only on DD. valid_out=0 at N+5.
- Back-to-back: 0x04030201 then 0x08070605 with valid_in always high → 8 contiguous output cycles 01..08. ready_in high only at the accept edges (the initial empty cycle and the lane-3 cycle).
- Backpressure: ready_out toggled 1,0,0,1,0,1,1 → every lane appears exactly once, in order. data_out and lane_out stay stable during stalls. ready_in=0 until the lane-3 transfer.
- Upstream gap: valid_in low for 3 cycles after a word drains → valid_out=0 throughout the gap. No spurious lanes. Next word starts at lane 0.
- Random soak (DW=12): random valid_in/ready_out, 10k words → scoreboard output equals input words split LSB-lane first. No loss or duplication. The valid-stability assertion holds.
